// File: rtl/rc6_decrypt_core.sv
// rc6_decrypt_core: iterative RC6-W/R decryption, one round per clock.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   in_valid/in_ready, cipher_a..d   ciphertext handshake and words A..D
//   round_keys                       S[0..2R+3], S[j] = round_keys[j*W +: W], sampled live
//   out_valid/out_ready, plain_a..d  plaintext handshake and words A..D
//   busy                             block is not idle
module rc6_decrypt_core #(
    parameter int W = 32,
    parameter int R = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         cipher_a,
    input  logic [W-1:0]         cipher_b,
    input  logic [W-1:0]         cipher_c,
    input  logic [W-1:0]         cipher_d,
    input  logic [(2*R+4)*W-1:0] round_keys,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         plain_a,
    output logic [W-1:0]         plain_b,
    output logic [W-1:0]         plain_c,
    output logic [W-1:0]         plain_d,
    output logic                 busy
);
    localparam int LGW = $clog2(W);
    typedef enum logic [1:0] {IDLE, ROUND, POST, DONE} state_t;
    state_t state_q, state_d;
    logic [W-1:0] a_q, b_q, c_q, d_q, a_d, b_d, c_d, d_d;
    logic [7:0] i_q, i_d;
    logic in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;
    logic [W-1:0] s_even, s_odd, s_0, s_1, s_r2, s_r3, t, u;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LGW-1:0] n);
        return (x << n) | (x >> (W - int'(n)));
    endfunction

    function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [LGW-1:0] n);
        return (x >> n) | (x << (W - int'(n)));
    endfunction

    // (x*(2x+1)) rotl lg(W); 2x+1 mod 2^W is just x shifted with a 1 in the LSB
    function automatic logic [W-1:0] mix(input logic [W-1:0] x);
        return rotl(x * {x[W-2:0], 1'b1}, LGW'(LGW));
    endfunction

    assign s_even = round_keys[2*int'(i_q)*W +: W];
    assign s_odd  = round_keys[(2*int'(i_q)+1)*W +: W];
    assign s_0    = round_keys[0 +: W];
    assign s_1    = round_keys[W +: W];
    assign s_r2   = round_keys[(2*R+2)*W +: W];
    assign s_r3   = round_keys[(2*R+3)*W +: W];
    // Round operates on the rotated view (a,b,c,d) = (D,A,B,C)
    assign t = mix(a_q);
    assign u = mix(c_q);

    always_comb begin
        state_d = state_q;
        a_d = a_q;
        b_d = b_q;
        c_d = c_q;
        d_d = d_q;
        i_d = i_q;
        case (state_q)
            IDLE: if (in_valid && in_ready_q) begin
                a_d = cipher_a - s_r2;
                b_d = cipher_b;
                c_d = cipher_c - s_r3;
                d_d = cipher_d;
                i_d = 8'(R);
                state_d = ROUND;
            end
            ROUND: begin
                a_d = rotr(d_q - s_even, u[LGW-1:0]) ^ t;
                b_d = a_q;
                c_d = rotr(b_q - s_odd, t[LGW-1:0]) ^ u;
                d_d = c_q;
                i_d = i_q - 8'd1;
                state_d = (i_q <= 8'd1) ? POST : ROUND;
            end
            POST: begin
                b_d = b_q - s_0;
                d_d = d_q - s_1;
                state_d = DONE;
            end
            DONE: state_d = (out_valid_q && out_ready) ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
        busy_d = (state_d != IDLE);
        // out_valid is a registered Moore output: it rises the cycle after DONE is entered
        out_valid_d = (state_q == DONE) && !(out_valid_q && out_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
            d_q <= '0;
            i_q <= '0;
            in_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            b_q <= b_d;
            c_q <= c_d;
            d_q <= d_d;
            i_q <= i_d;
            in_ready_q <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q <= busy_d;
        end
    end

    assign in_ready = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy = busy_q;
    assign plain_a = a_q;
    assign plain_b = b_q;
    assign plain_c = c_q;
    assign plain_d = d_q;
endmodule
